// File: rtl/alarm_panel_ctrl_pkg.sv
// Shared types and constants for the zone alarm panel controller.
// Delay defaults match the zone gate's top level.
package alarm_pkg;

    typedef enum logic [2:0] {
        DISARMED    = 3'd0,
        EXIT_DELAY  = 3'd1,
        ARMED       = 3'd2,
        ENTRY_DELAY = 3'd3,
        SOUNDING    = 3'd4
    } state_t;

    localparam int DEF_EXIT_CYCLES  = 16;
    localparam int DEF_ENTRY_CYCLES = 16;
    localparam int DEF_SIREN_CYCLES = 64;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/alarm_panel_ctrl_if.sv
// Panel-side bundle: keypad requests and gate trip in, gate enable,
// beeper and siren out.
interface alarm_panel_ctrl_if;

    logic Alarm_State;
    logic Arm;
    logic Disarm;
    logic Armed;
    logic Pending;
    logic Siren;

    modport master (
        output Alarm_State, Arm, Disarm,
        input  Armed, Pending, Siren
    );

    modport slave (
        input  Alarm_State, Arm, Disarm,
        output Armed, Pending, Siren
    );

endinterface

// File: rtl/alarm_panel_ctrl_delay_counter.sv
// Shared delay down-counter: loadable, saturates at zero.
// Reports zero so the FSM can time exit, entry and siren windows.
module alarm_delay_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/alarm_panel_ctrl.sv
// Zone alarm panel FSM: arm/disarm, exit and entry delays, siren.
// Define SIREN_TIMEOUT_EN to time the siren out back to ARMED.
module alarm_panel_ctrl
    import alarm_pkg::*;
#(
    parameter int EXIT_CYCLES  = DEF_EXIT_CYCLES,
    parameter int ENTRY_CYCLES = DEF_ENTRY_CYCLES,
    parameter int SIREN_CYCLES = DEF_SIREN_CYCLES
) (
    input  logic              Clk,
    input  logic              Reset,
    alarm_panel_ctrl_if.slave zone
);

    localparam int CW = cnt_width(EXIT_CYCLES, ENTRY_CYCLES, SIREN_CYCLES);

    localparam logic [CW-1:0] EXIT_LD  = CW'(EXIT_CYCLES - 1);
    localparam logic [CW-1:0] ENTRY_LD = CW'(ENTRY_CYCLES - 1);
`ifdef SIREN_TIMEOUT_EN
    localparam logic [CW-1:0] SIREN_LD = CW'(SIREN_CYCLES - 1);
`endif

    state_t        state;
    state_t        nxt;
    logic          trip_m;
    logic          trip_s;
    logic          load;
    logic [CW-1:0] load_val;
    logic          dec;
    logic          zero;

    // Alarm_State is asynchronous to Clk
    always_ff @(posedge Clk) begin
        if (Reset) begin
            trip_m <= 1'b0;
            trip_s <= 1'b0;
        end else begin
            trip_m <= zone.Alarm_State;
            trip_s <= trip_m;
        end
    end

    always_comb begin
        nxt      = state;
        load     = 1'b0;
        load_val = '0;
        dec      = 1'b0;
        if (zone.Disarm) begin
            nxt = DISARMED;
        end else begin
            unique case (state)
                DISARMED: begin
                    if (zone.Arm) begin
                        nxt      = EXIT_DELAY;
                        load     = 1'b1;
                        load_val = EXIT_LD;
                    end
                end
                EXIT_DELAY: begin
                    if (zero) nxt = ARMED;
                    else      dec = 1'b1;
                end
                ARMED: begin
                    if (trip_s) begin
                        nxt      = ENTRY_DELAY;
                        load     = 1'b1;
                        load_val = ENTRY_LD;
                    end
                end
                ENTRY_DELAY: begin
                    if (zero) begin
                        nxt = SOUNDING;
`ifdef SIREN_TIMEOUT_EN
                        load     = 1'b1;
                        load_val = SIREN_LD;
`endif
                    end else begin
                        dec = 1'b1;
                    end
                end
                SOUNDING: begin
`ifdef SIREN_TIMEOUT_EN
                    if (zero) nxt = ARMED;
                    else      dec = 1'b1;
`else
                    nxt = SOUNDING;
`endif
                end
                default: nxt = DISARMED;
            endcase
        end
    end

    // Outputs registered from the next state so they track the state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= DISARMED;
            zone.Armed   <= 1'b0;
            zone.Pending <= 1'b0;
            zone.Siren   <= 1'b0;
        end else begin
            state        <= nxt;
            zone.Armed   <= (nxt == ARMED) || (nxt == ENTRY_DELAY)
                         || (nxt == SOUNDING);
            zone.Pending <= (nxt == EXIT_DELAY) || (nxt == ENTRY_DELAY);
            zone.Siren   <= (nxt == SOUNDING);
        end
    end

    alarm_delay_counter #(.W(CW)) u_cnt (
        .clk      (Clk),
        .rst      (Reset),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .zero     (zero)
    );

endmodule

// File: tb/tb_alarm_panel_ctrl.sv
// Scoreboard bench for alarm_panel_ctrl: expected {Armed,Pending,Siren}
// pushed per driven cycle, popped and compared one cycle later.
module tb_alarm_panel_ctrl;

    localparam logic [2:0] OFF = 3'b000;
    localparam logic [2:0] EXT = 3'b010;
    localparam logic [2:0] ARM = 3'b100;
    localparam logic [2:0] ENT = 3'b110;
    localparam logic [2:0] SND = 3'b101;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    alarm_panel_ctrl_if zone ();

    alarm_panel_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .zone  (zone)
    );

    int total = 0;
    int bad = 0;
    logic [2:0] exp_q[$];
    logic [2:0] got;
    logic [2:0] want;

    task automatic test_reset();
        zone.Arm = 1'b1;
        zone.Disarm = 1'b1;
        zone.Alarm_State = 1'b1;
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                Reset = 1'b0;
                zone.Arm = 1'b0;
                zone.Disarm = 1'b0;
                zone.Alarm_State = 1'b0;
            end
            exp_q.push_back(OFF);
            @(posedge Clk); #1;
            got = {zone.Armed, zone.Pending, zone.Siren};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset c%0d got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_arm_exit();
        for (int i = 0; i < 19; i++) begin
            zone.Arm = (i == 0);
            zone.Alarm_State = (i < 12) && i[0];
            exp_q.push_back(i < 16 ? EXT : ARM);
            @(posedge Clk); #1;
            got = {zone.Armed, zone.Pending, zone.Siren};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL arm_exit c%0d got=%b want=%b", i, got, want);
            end
        end
        zone.Alarm_State = 1'b0;
    endtask

`ifdef SIREN_TIMEOUT_EN
    localparam int SN = 85;
`else
    localparam int SN = 27;
`endif

    task automatic test_entry_siren();
        logic [2:0] e;
        for (int i = 0; i < SN; i++) begin
            zone.Disarm = (i == SN - 1);
`ifdef SIREN_TIMEOUT_EN
            zone.Alarm_State = (i < SN - 1);
            if (i < 2)       e = ARM;
            else if (i < 18) e = ENT;
            else if (i < 82) e = SND;
            else if (i < 83) e = ARM;
            else if (i < 84) e = ENT;
            else             e = OFF;
`else
            zone.Alarm_State = (i < 4);
            if (i < 2)           e = ARM;
            else if (i < 18)     e = ENT;
            else if (i < SN - 1) e = SND;
            else                 e = OFF;
`endif
            exp_q.push_back(e);
            @(posedge Clk); #1;
            got = {zone.Armed, zone.Pending, zone.Siren};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL entry_siren c%0d got=%b want=%b", i, got, want);
            end
        end
        zone.Disarm = 1'b0;
        zone.Alarm_State = 1'b0;
    endtask

    task automatic test_disarm_entry();
        logic [2:0] e;
        for (int i = 0; i < 28; i++) begin
            zone.Arm = (i == 0);
            zone.Alarm_State = (i == 17);
            zone.Disarm = (i == 24);
            if (i < 16)      e = EXT;
            else if (i < 19) e = ARM;
            else if (i < 24) e = ENT;
            else             e = OFF;
            exp_q.push_back(e);
            @(posedge Clk); #1;
            got = {zone.Armed, zone.Pending, zone.Siren};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL disarm_entry c%0d got=%b want=%b", i, got, want);
            end
        end
        zone.Disarm = 1'b0;
    endtask

    task automatic test_arm_disarm_same();
        for (int i = 0; i < 9; i++) begin
            zone.Arm = 1'b1;
            zone.Disarm = (i < 3) || (i == 6);
            exp_q.push_back(zone.Disarm ? OFF : EXT);
            @(posedge Clk); #1;
            got = {zone.Armed, zone.Pending, zone.Siren};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL arm_disarm c%0d got=%b want=%b", i, got, want);
            end
        end
        zone.Disarm = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            zone.Arm = 1'b0;
            Reset = (i == 0);
            exp_q.push_back(OFF);
            @(posedge Clk); #1;
            got = {zone.Armed, zone.Pending, zone.Siren};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_mid c%0d got=%b want=%b", i, got, want);
            end
        end
        Reset = 1'b0;
    endtask

    initial begin
        zone.Arm = 1'b0;
        zone.Disarm = 1'b0;
        zone.Alarm_State = 1'b0;
        test_reset();
        test_arm_exit();
        test_entry_siren();
        test_disarm_entry();
        test_arm_disarm_same();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_panel_ctrl.md
Name: alarm_panel_ctrl

Overview:
- Sequential panel controller for the zone alarm gate, the consuming end of its Enable/Alarm_State interface.
- Drives the gate's Enable through Armed, and receives the gate's Alarm_State.
- Provides arm/disarm handling, an exit delay, an entry delay and siren control.
- Moore FSM with a shared down-counter for all delays.

Parameters:
- EXIT_CYCLES, 16, cycles spent in exit delay after Arm before the system is armed (min 1).
- ENTRY_CYCLES, 16, cycles of grace after a trip before the siren sounds (min 1).
- SIREN_CYCLES, 64, siren duration when SIREN_TIMEOUT_EN is defined (min 1).

Ports:
- Clk  input  1  system clock, all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Alarm_State  input  1  trip from the zone gate; asynchronous to Clk.
- Arm  input  1  arm request; level, sampled each cycle.
- Disarm  input  1  disarm request; level, sampled each cycle.
- Armed  output  1  high in ARMED, ENTRY_DELAY and SOUNDING; wired to the gate's Enable.
- Pending  output  1  high in EXIT_DELAY and ENTRY_DELAY; drives the keypad beeper.
- Siren  output  1  high only in SOUNDING.

Behaviour:
- Clock and reset:
  - Single clock domain, Clk.
  - Reset is synchronous and active-high: with Reset high at an edge, state becomes DISARMED and the counter becomes 0.
  - All outputs are decoded from the state register only (Moore), so all are 0 after reset.
  - Reset overrides every other input, including mid-delay and while SOUNDING.
- Input synchronisation:
  - Alarm_State passes through a 2-flop synchroniser (trip_s); both flops clear on Reset.
  - A trip sampled at edge k is seen by the FSM at edge k+2.
- States: DISARMED, EXIT_DELAY, ARMED, ENTRY_DELAY, SOUNDING.
- Transitions, evaluated at each edge, in priority order:
  - Disarm high: go to DISARMED from any state. Disarm beats Arm, and beats a trip arriving on the same cycle.
  - DISARMED with Arm high: go to EXIT_DELAY and load the counter with EXIT_CYCLES-1.
  - EXIT_DELAY:
    - Counter decrements each cycle.
    - When counter == 0, go to ARMED, so EXIT_DELAY lasts exactly EXIT_CYCLES cycles.
    - trip_s is ignored in this state.
  - ARMED with trip_s high: go to ENTRY_DELAY and load the counter with ENTRY_CYCLES-1.
  - ENTRY_DELAY:
    - Counter decrements each cycle.
    - When counter == 0, go to SOUNDING.
    - trip_s dropping does not cancel; only Disarm or Reset cancels.
  - SOUNDING: stays until Disarm or Reset (see the optional feature for the timeout).
- Arm outside DISARMED is ignored.
- Holding Arm high re-arms only after passing through DISARMED.
- Counter:
  - Width is $clog2 of the largest parameter plus 1, unsigned.
  - Saturates at 0; it never wraps.
  - Loads only on the transitions listed above.

Optional Feature:
- Macro SIREN_TIMEOUT_EN.
- When defined:
  - Entering SOUNDING loads the counter with SIREN_CYCLES-1.
  - At counter == 0 the FSM returns to ARMED, not DISARMED, so the system stays armed.
  - A trip still high at that point re-enters ENTRY_DELAY on the following edge.
- When undefined:
  - SOUNDING is terminal until Disarm or Reset.
  - The counter is held at 0 in SOUNDING.
  - SIREN_CYCLES is unused.

Decomposition:
- Package alarm_pkg holds:
  - The state typedef (5 states, 3-bit encoding).
  - The localparam counter width function/constant.
  - Default delay constants shared with the zone gate's top level.
- One sub-module, alarm_delay_counter:
  - Inputs: load, load value, enable decrement.
  - Output: zero flag.
- The synchroniser stays inline.

Test Plan (all with default parameters):
- Reset with Arm, Disarm and Alarm_State high -> Armed, Pending and Siren stay 0 while Reset is held; state is DISARMED on release.
- Arm pulse at edge 0 -> Pending=1 for cycles 1..16; Armed=1 and Pending=0 from cycle 17; Siren=0.
- Exit window:
  - Alarm_State toggled during exit delay -> ignored; ARMED reached on schedule.
  - Then Alarm_State high at edge k -> Pending=1 from k+2 for 16 cycles; Siren=1 from k+18.
- Disarm asserted in ENTRY_DELAY at cycle 5 of the delay -> all outputs 0 the next cycle.
- Disarm while SOUNDING -> Siren 0 the next cycle.
- Arm and Disarm high on the same edge in DISARMED -> stays DISARMED.
- SIREN_TIMEOUT_EN defined:
  - Siren high for exactly 64 cycles, then Armed=1 and Siren=0.
  - Alarm_State held high -> ENTRY_DELAY re-entered on the next edge.
